prime_pair_sched: RTL and testbench
===================================

# prime_pair_sched

Sequencer for the nearest-prime search. It accepts one 14-bit intake value and finds the nearest prime strictly above it and the nearest prime strictly below it by trial division. Two search engines, UP and LOW, share a single remainder/compare datapath under a round-robin scheduler. The block sits in place of the lab's prime finder and drives its UpPrime/LowPrime/out_valid result interface.

## Interface
- WIDTH, 14: intake/candidate width.
- ROOT_W, 8: isqrt output width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- give_valid  in  1  start request; sampled only when not busy.
- Intake  in  WIDTH  value N, latched on an accepted give_valid.
- UpPrime  out  WIDTH  smallest prime > N, or 0 if none fits in WIDTH.
- LowPrime  out  WIDTH  largest prime < N, or 0 if none exists.
- out_valid  out  1  results valid; a level, not a pulse.
- busy  out  1  search in progress.

## Operation
- States: IDLE, SEARCH, DONE.
- **Accept.** give_valid in IDLE or DONE latches N.
  - UP engine starts at cand_u = N+1, LOW engine at cand_l = N-1; both divisors d = 2.
  - Round-robin pointer is set to UP; state goes to SEARCH.
- **Immediate completion at accept.**
  - N <= 2: low_done = 1, LowPrime = 0.
  - N >= 16381: up_done = 1, UpPrime = 0. 16381 is the largest 14-bit prime.
- **Grant.** One engine per cycle.
  - Both engines pending: alternate, starting with UP.
  - Only one pending: it is granted every cycle.
- **Granted engine, candidate c, divisor d.** Exactly one action per grant:
  - c < 2: composite; step c, d = 2.
  - d > isqrt(c): c is prime; store it to UpPrime/LowPrime and set the done flag.
  - c % d == 0: composite; step c (UP +1, LOW -1), d = 2.
  - Otherwise: d = d + 1.
- isqrt(c) is exact floor(sqrt(c)) for every c in 0..16383, including perfect squares (isqrt(9) = 3, isqrt(4) = 2).
- Modulo is computed combinationally on the granted engine's c and d only; there is one shared remainder unit.
- When both done flags are set, state goes to DONE: out_valid = 1, busy = 0, results held.
- give_valid during SEARCH is ignored. Intake changes after accept have no effect.
- Reset low at any clock edge, including mid-SEARCH:
  - state IDLE; UpPrime = 0, LowPrime = 0; out_valid = 0, busy = 0.
  - done flags, candidates, divisors and pointer cleared.

## Timing
- Accepting edge E0: busy = 1 and out_valid = 0 from E0.
- Grants evaluate on edges E1, E2, ...
- The edge on which the last done flag sets enters DONE; out_valid is high from that edge.
- Latency equals the total number of grants consumed by both engines.
  - Example, N = 10: UP needs 3 grants, LOW needs 5, so out_valid rises at E8.
- If both engines complete at accept (not possible for 14-bit N): DONE at E1.
- New give_valid in DONE: out_valid drops at that accepting edge. Outputs keep their old values until overwritten by the new search.
- No combinational path from give_valid or Intake to any output.

## Structure
- Shared package holds:
  - WIDTH, ROOT_W, MAX_PRIME = 16381.
  - State enum {IDLE, SEARCH, DONE}.
  - Engine select enum {ENG_UP, ENG_LOW}.
- Sub-module prime_isqrt: combinational, WIDTH in to ROOT_W out, floor square root, defined for all inputs with no latches.
- The scheduler, both engine register sets, the shared remainder unit and the output registers live in the top module.

## Test plan
- reset = 0 asserted mid-SEARCH for N = 1000 -> next edge: UpPrime = 0, LowPrime = 0, out_valid = 0, busy = 0; a new give_valid then completes normally (1009 / 997).
- N = 10 -> UpPrime = 11, LowPrime = 7, out_valid high exactly 8 edges after accept; grant order checked U,L,U,L,U,L,L,L.
- Perfect-square rejection:
  - N = 24 -> UpPrime = 29 (25 rejected via d = 5), LowPrime = 23.
  - N = 8 -> UpPrime = 11 (9 rejected), LowPrime = 7.
- Low-end edges:
  - N = 0 -> UpPrime = 2, LowPrime = 0.
  - N = 2 -> UpPrime = 3, LowPrime = 0.
  - N = 3 -> UpPrime = 5, LowPrime = 2.
- Top edge: N = 16383 -> UpPrime = 0, LowPrime = 16381; N = 16381 -> UpPrime = 0.
- Handshake:
  - give_valid pulses during SEARCH are ignored and results match the first N.
  - give_valid in the same cycle out_valid is high: new N = 100 accepted, out_valid drops, final result UpPrime = 101, LowPrime = 97.

Source files
------------

// File: rtl/prime_pair_sched_pkg.sv
// Shared types and constants for the nearest-prime pair sequencer.
package prime_pair_sched_pkg;

    localparam int WIDTH  = 14;
    localparam int ROOT_W = 8;

    // Largest prime representable in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_PRIME = 14'd16381;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        ENG_UP  = 1'b0,
        ENG_LOW = 1'b1
    } eng_sel_e;

    // Round-robin successor of an engine select.
    function automatic eng_sel_e other_eng(input eng_sel_e e);
        eng_sel_e r;
        if (e == ENG_UP) begin
            r = ENG_LOW;
        end else begin
            r = ENG_UP;
        end
        return r;
    endfunction

endpackage

// File: rtl/prime_pair_sched_if.sv
// Request/result bundle of the nearest-prime pair sequencer.
interface prime_pair_sched_if;
    import prime_pair_sched_pkg::*;

    logic             give_valid;
    logic [WIDTH-1:0] Intake;
    logic [WIDTH-1:0] UpPrime;
    logic [WIDTH-1:0] LowPrime;
    logic             out_valid;
    logic             busy;

    modport master (
        output give_valid, Intake,
        input  UpPrime, LowPrime, out_valid, busy
    );

    modport slave (
        input  give_valid, Intake,
        output UpPrime, LowPrime, out_valid, busy
    );
endinterface

// File: rtl/prime_pair_sched_isqrt.sv
// Combinational floor square root, one trial bit per root bit (MSB first).
module prime_isqrt
    import prime_pair_sched_pkg::*;
(
    input  logic [WIDTH-1:0]  value_i,
    output logic [ROOT_W-1:0] root_o
);

    logic [ROOT_W-1:0]   root_s;
    logic [ROOT_W-1:0]   trial_s;
    logic [2*ROOT_W-1:0] sq_s;

    // Greedy bit-by-bit root: keep a trial bit whenever its square still fits.
    always_comb begin
        root_s  = '0;
        trial_s = '0;
        sq_s    = '0;
        for (int b = ROOT_W - 1; b >= 0; b--) begin
            trial_s = root_s | (ROOT_W'(1) << b);
            sq_s    = {{ROOT_W{1'b0}}, trial_s} * {{ROOT_W{1'b0}}, trial_s};
            if (sq_s <= {{(2*ROOT_W-WIDTH){1'b0}}, value_i}) begin
                root_s = trial_s;
            end else begin
                root_s = root_s;
            end
        end
        root_o = root_s;
    end

endmodule

// File: rtl/prime_pair_sched.sv
// Nearest-prime pair sequencer: UP and LOW trial-division engines sharing
// one remainder/compare datapath under a round-robin grant.
module prime_pair_sched
    import prime_pair_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    prime_pair_sched_if.slave  bus
);

    state_e            state_q, state_d;
    eng_sel_e          ptr_q, ptr_d;
    eng_sel_e          grant_s;
    logic [WIDTH-1:0]  cand_u_q, cand_u_d, cand_l_q, cand_l_d;
    logic [ROOT_W-1:0] div_u_q, div_u_d, div_l_q, div_l_d;
    logic              up_done_q, up_done_d, low_done_q, low_done_d;
    logic [WIDTH-1:0]  up_prime_q, up_prime_d, low_prime_q, low_prime_d;
    logic              out_valid_q, out_valid_d, busy_q, busy_d;

    logic [WIDTH-1:0]  cand_s;
    logic [ROOT_W-1:0] div_s;
    logic [ROOT_W-1:0] root_s;
    logic [WIDTH-1:0]  rem_s;
    logic              step_s;
    logic              found_s;

    // Pick the granted engine and classify its current (candidate, divisor).
    always_comb begin
        grant_s = ptr_q;
        if (up_done_q) begin
            grant_s = ENG_LOW;
        end else if (low_done_q) begin
            grant_s = ENG_UP;
        end else begin
            grant_s = ptr_q;
        end

        case (grant_s)
            ENG_UP:  begin cand_s = cand_u_q; div_s = div_u_q; end
            ENG_LOW: begin cand_s = cand_l_q; div_s = div_l_q; end
            default: begin cand_s = cand_u_q; div_s = div_u_q; end
        endcase

        rem_s   = cand_s % {{(WIDTH-ROOT_W){1'b0}}, div_s};
        step_s  = 1'b0;
        found_s = 1'b0;
        if (cand_s < 14'd2) begin
            step_s = 1'b1;
        end else if (div_s > root_s) begin
            found_s = 1'b1;
        end else if (rem_s == 14'd0) begin
            step_s = 1'b1;
        end else begin
            step_s  = 1'b0;
            found_s = 1'b0;
        end
    end

    prime_isqrt u_isqrt (
        .value_i (cand_s),
        .root_o  (root_s)
    );

    // Next-state: accept, per-grant engine action, completion detection.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cand_u_d    = cand_u_q;
        cand_l_d    = cand_l_q;
        div_u_d     = div_u_q;
        div_l_d     = div_l_q;
        up_done_d   = up_done_q;
        low_done_d  = low_done_q;
        up_prime_d  = up_prime_q;
        low_prime_d = low_prime_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.give_valid) begin
                    state_d     = SEARCH;
                    ptr_d       = ENG_UP;
                    cand_u_d    = bus.Intake + 14'd1;
                    cand_l_d    = bus.Intake - 14'd1;
                    div_u_d     = 8'd2;
                    div_l_d     = 8'd2;
                    up_done_d   = (bus.Intake >= MAX_PRIME);
                    low_done_d  = (bus.Intake <= 14'd2);
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    // Engines that cannot find a prime report 0 right away.
                    if (up_done_d) begin
                        up_prime_d = 14'd0;
                    end else begin
                        up_prime_d = up_prime_q;
                    end
                    if (low_done_d) begin
                        low_prime_d = 14'd0;
                    end else begin
                        low_prime_d = low_prime_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            SEARCH: begin
                // Alternate only while both engines still compete.
                if (!up_done_q && !low_done_q) begin
                    ptr_d = other_eng(ptr_q);
                end else begin
                    ptr_d = ptr_q;
                end
                if (!(up_done_q && low_done_q)) begin
                    if (grant_s == ENG_UP) begin
                        if (step_s) begin
                            cand_u_d = cand_u_q + 14'd1;
                            div_u_d  = 8'd2;
                        end else if (found_s) begin
                            up_prime_d = cand_u_q;
                            up_done_d  = 1'b1;
                        end else begin
                            div_u_d = div_u_q + 8'd1;
                        end
                    end else begin
                        if (step_s) begin
                            cand_l_d = cand_l_q - 14'd1;
                            div_l_d  = 8'd2;
                        end else if (found_s) begin
                            low_prime_d = cand_l_q;
                            low_done_d  = 1'b1;
                        end else begin
                            div_l_d = div_l_q + 8'd1;
                        end
                    end
                end else begin
                    ptr_d = ptr_q;
                end
                if (up_done_d && low_done_d) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= ENG_UP;
            cand_u_q    <= 14'd0;
            cand_l_q    <= 14'd0;
            div_u_q     <= 8'd0;
            div_l_q     <= 8'd0;
            up_done_q   <= 1'b0;
            low_done_q  <= 1'b0;
            up_prime_q  <= 14'd0;
            low_prime_q <= 14'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cand_u_q    <= cand_u_d;
            cand_l_q    <= cand_l_d;
            div_u_q     <= div_u_d;
            div_l_q     <= div_l_d;
            up_done_q   <= up_done_d;
            low_done_q  <= low_done_d;
            up_prime_q  <= up_prime_d;
            low_prime_q <= low_prime_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.UpPrime   = up_prime_q;
    assign bus.LowPrime  = low_prime_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_prime_pair_sched.sv
// Self-checking bench for prime_pair_sched: arithmetic reference model,
// per-cycle compare process, directed edge cases and randomized intakes.
module tb_prime_pair_sched;
    import prime_pair_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;

    prime_pair_sched_if bus();

    prime_pair_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit m_busy, m_ov, m_known;
    int m_up, m_low, m_left;

    function automatic int isqrt_ref(input int c);
        int r = 0;
        while ((r + 1) * (r + 1) <= c) r++;
        return r;
    endfunction

    function automatic bit is_prime(input int c);
        if (c < 2) return 1'b0;
        for (int d = 2; d * d <= c; d++) if (c % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_up(input int n);
        for (int c = n + 1; c <= 16383; c++) if (is_prime(c)) return c;
        return 0;
    endfunction

    function automatic int ref_low(input int n);
        for (int c = n - 1; c >= 2; c--) if (is_prime(c)) return c;
        return 0;
    endfunction

    // Grants one engine consumes: a prime c costs isqrt(c) tries, a composite
    // costs (smallest factor - 1) tries, and c < 2 costs one.
    function automatic int grants_eng(input int n, input bit up);
        int c;
        int total = 0;
        int f;
        if (up && n >= 16381) return 0;
        if (!up && n <= 2) return 0;
        c = up ? n + 1 : n - 1;
        forever begin
            if (c < 2) begin
                total++;
            end else if (is_prime(c)) begin
                return total + isqrt_ref(c);
            end else begin
                f = 2;
                while (c % f != 0) f++;
                total += f - 1;
            end
            c = up ? c + 1 : c - 1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on the same edges the DUT samples.
    always @(posedge clk) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_ov    <= 1'b0;
            m_known <= 1'b1;
            m_up    <= 0;
            m_low   <= 0;
            m_left  <= 0;
        end else if (!m_busy && bus.give_valid) begin
            m_busy  <= 1'b1;
            m_ov    <= 1'b0;
            m_known <= 1'b0;
            m_up    <= ref_up(int'(bus.Intake));
            m_low   <= ref_low(int'(bus.Intake));
            m_left  <= grants_eng(int'(bus.Intake), 1'b1) + grants_eng(int'(bus.Intake), 1'b0);
        end else if (m_busy) begin
            if (m_left <= 1) begin
                m_busy  <= 1'b0;
                m_ov    <= 1'b1;
                m_known <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("out_valid", int'(bus.out_valid), int'(m_ov));
            if (m_known) begin
                chk("UpPrime", int'(bus.UpPrime), m_up);
                chk("LowPrime", int'(bus.LowPrime), m_low);
            end
        end
    end

    // Issue one request at a negedge and wait for completion (ends at a negedge).
    task automatic run_search(input int n, input int lit_up, input int lit_low,
                              input int lit_lat, input bit noise);
        int q[$];
        int gu, gl, lat_m, seen, a, b, ptr, e;
        bit done;
        gu    = grants_eng(n, 1'b1);
        gl    = grants_eng(n, 1'b0);
        lat_m = gu + gl;
        bus.give_valid = 1'b1;
        bus.Intake     = 14'(n);
        @(negedge clk);
        bus.give_valid = 1'b0;
        chk("ov_after_accept", int'(bus.out_valid), 0);
        q.push_back(int'(dut.grant_s));
        done = 1'b0;
        seen = 0;
        for (int i = 1; i <= 4000 && !done; i++) begin
            @(negedge clk);
            bus.give_valid = 1'b0;
            if (bus.out_valid) begin
                done = 1'b1;
                seen = i;
            end else begin
                q.push_back(int'(dut.grant_s));
                if (noise) begin
                    bus.give_valid = 1'($urandom_range(0, 1));
                    bus.Intake     = 14'($urandom);
                end
            end
        end
        if (!done) begin
            chk("timeout", 0, 1);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        chk("latency", seen, lat_m);
        if (lit_lat >= 0) chk("latency_lit", seen, lit_lat);
        if (lit_up >= 0)  chk("up_lit", int'(bus.UpPrime), lit_up);
        if (lit_low >= 0) chk("low_lit", int'(bus.LowPrime), lit_low);
        chk("grant_count", q.size(), lat_m);
        a = gu; b = gl; ptr = 0;
        for (int k = 0; k < lat_m && k < q.size(); k++) begin
            if (a > 0 && b > 0) begin
                e = ptr;
                if (ptr == 0) a--; else b--;
                ptr = 1 - ptr;
            end else if (a > 0) begin
                e = 0; a--;
            end else begin
                e = 1; b--;
            end
            chk("grant_order", q[k], e);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.give_valid = 1'b0;
        bus.Intake     = 14'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_up", int'(bus.UpPrime), 0);
        chk("rst_low", int'(bus.LowPrime), 0);
        chk("rst_ov", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Pin the model with hand-computed values.
        chk("model_up24", ref_up(24), 29);
        chk("model_low3", ref_low(3), 2);
        chk("model_lat10", grants_eng(10, 1'b1) + grants_eng(10, 1'b0), 8);

        run_search(10, 11, 7, 8, 1'b0);
        run_search(24, 29, 23, -1, 1'b0);
        run_search(8, 11, 7, -1, 1'b0);
        run_search(0, 2, 0, -1, 1'b0);
        run_search(2, 3, 0, -1, 1'b0);
        run_search(3, 5, 2, -1, 1'b0);
        run_search(16383, 0, 16381, -1, 1'b0);
        run_search(16381, 0, -1, -1, 1'b0);

        // Reset in the middle of a search.
        bus.give_valid = 1'b1;
        bus.Intake     = 14'd1000;
        @(negedge clk);
        bus.give_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_up", int'(bus.UpPrime), 0);
        chk("midrst_low", int'(bus.LowPrime), 0);
        chk("midrst_ov", int'(bus.out_valid), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        reset = 1'b1;
        @(negedge clk);
        run_search(1000, 1009, 997, -1, 1'b0);

        // Ignored requests during search, then back-to-back accept in DONE.
        run_search(500, 503, 499, -1, 1'b1);
        run_search(100, 101, 97, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_search(int'($urandom_range(0, 16383)), -1, -1, -1, 1'(i % 2));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
